// File: rtl/vga_vram_arbiter.sv
// Arbitrates a single-port VRAM between VGA scanout reads (priority) and buffered CPU
// pixel writes, with a starvation guard that forces a write after a run of read grants.
module vga_vram_arbiter #(
    parameter int GRID_W       = 16,
    parameter int GRID_H       = 13,
    parameter int MEM_AW       = 8,
    parameter int COLOR_W      = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_enable,
    input  logic [15:0]        wr_address,
    input  logic [COLOR_W-1:0] wr_color,
    output logic               wr_stall,
    input  logic               rd_request,
    input  logic [15:0]        rd_address,
    output logic               rd_valid,
    output logic               rd_miss,
    output logic [COLOR_W-1:0] rd_data,
    output logic               mem_enable,
    output logic               mem_write,
    output logic [MEM_AW-1:0]  mem_address,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [2:0]         fifo_level,
    output logic               addr_error,
    input  logic               clear_error
);

    localparam int PIXELS = GRID_W * GRID_H;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(STARVE_LIMIT + 1);

    // Write FIFO: addresses are range-checked before push, so only MEM_AW bits are kept.
    logic [MEM_AW-1:0]  fifo_addr  [FIFO_DEPTH];
    logic [COLOR_W-1:0] fifo_color [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [2:0]         level;
    logic [CW-1:0]      starve_cnt;

    logic wr_in_range;
    logic rd_in_range;
    logic push;
    logic has_data;
    logic starve;
    logic rd_ok;
    logic grant_rd;
    logic grant_wr;
    logic err_set;

    // Read response pipeline: stage 1 records the decision, stage 2 presents it.
    logic               s1_granted;
    logic               s1_bad;
    logic               s1_miss;
    logic               s2_from_mem;
    logic [COLOR_W-1:0] rd_data_q;

    assign wr_in_range = (wr_address < 16'(PIXELS));
    assign rd_in_range = (rd_address < 16'(PIXELS));

    assign wr_stall   = (level == 3'(FIFO_DEPTH));
    assign fifo_level = level;

    assign push     = wr_enable && !wr_stall && wr_in_range;
    assign err_set  = wr_enable && !wr_stall && !wr_in_range;

    assign has_data = (level != 3'd0);
    assign starve   = (starve_cnt == CW'(STARVE_LIMIT)) && has_data;
    assign rd_ok    = rd_request && rd_in_range;
    assign grant_rd = rd_ok && !starve;
    assign grant_wr = !grant_rd && has_data;

    // Granted reads return straight from the VRAM output; other responses use the held value.
    assign rd_data = s2_from_mem ? mem_rdata : rd_data_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= wr_address[MEM_AW-1:0];
            fifo_color[wr_ptr] <= wr_color;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (grant_wr) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, grant_wr})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
        end
    end

    // Counts reads that overtook a waiting write; saturates so the guard stays armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_wr || !has_data) begin
            starve_cnt <= '0;
        end else if (grant_rd && (starve_cnt != CW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_enable  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else if (grant_rd) begin
            mem_enable  <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= rd_address[MEM_AW-1:0];
        end else if (grant_wr) begin
            mem_enable  <= 1'b1;
            mem_write   <= 1'b1;
            mem_address <= fifo_addr[rd_ptr];
            mem_wdata   <= fifo_color[rd_ptr];
        end else begin
            mem_enable  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_granted  <= 1'b0;
            s1_bad      <= 1'b0;
            s1_miss     <= 1'b0;
            s2_from_mem <= 1'b0;
            rd_valid    <= 1'b0;
            rd_miss     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            s1_granted  <= grant_rd;
            s1_bad      <= rd_request && !rd_in_range;
            s1_miss     <= rd_ok && starve;
            s2_from_mem <= s1_granted;
            rd_valid    <= s1_granted || s1_bad;
            rd_miss     <= s1_miss;
            // Capture the returned word so later misses keep showing it; a new
            // out-of-range response overrides the capture in the same edge.
            if (s2_from_mem) begin
                rd_data_q <= mem_rdata;
            end
            if (s1_bad) begin
                rd_data_q <= '0;
            end
        end
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_error <= 1'b0;
        end else if (err_set) begin
            addr_error <= 1'b1;
        end else if (clear_error) begin
            addr_error <= 1'b0;
        end
    end

endmodule
